regs_wb_arbiter: RTL and testbench
==================================

REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, entries per source queue (fixed at 2 for this revision).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush_i  input  1  synchronous discard of all queued writes.
REQ-005 ex_wvalid_i / ex_wready_o  input/output  1/1  EX writeback handshake.
REQ-006 ex_waddr_i / ex_wdata_i  input  5/32  EX destination register and data.
REQ-007 mem_wvalid_i / mem_wready_o  input/output  1/1  MEM (load) writeback handshake.
REQ-008 mem_waddr_i / mem_wdata_i  input  5/32  MEM destination register and data.
REQ-009 reg_wen_o / reg_waddr_o / reg_wdata_o  output  1/5/32  single register-file write port.
REQ-010 pending_o  output  32  bit n set while any queued write targets register n.

Function
REQ-011 Each source SHALL own a 2-entry FIFO (addr+data) with a 0..2 occupancy count.
REQ-012 x_wready_o SHALL be 1 when that FIFO count < 2 and flush_i = 0; no pop-through when full.
REQ-013 Transfer SHALL occur on an edge where x_wvalid_i & x_wready_o = 1.
REQ-014 Transfer with waddr = 0 SHALL be accepted but not enqueued (x0 writes dropped).
REQ-015 reg_wen_o SHALL be combinational: 1 whenever either FIFO is non-empty and flush_i = 0.
REQ-016 reg_waddr_o/reg_wdata_o SHALL equal the granted FIFO head; all-zero when reg_wen_o = 0.
REQ-017 Granted head SHALL be popped on the same edge the register file samples the write.
REQ-018 Latency: a write accepted at edge k SHALL appear on the write port at the earliest in the cycle after edge k, committed at edge k+1.
REQ-019 Grant: only one FIFO non-empty -> grant it; both non-empty -> grant the source not in last_grant.
REQ-020 last_grant (1 bit, 0=EX, 1=MEM) SHALL update to the granted source on every pop; unchanged when idle.
REQ-021 Simultaneous push and pop on the same FIFO SHALL keep count unchanged and preserve order.
REQ-022 Per-source order SHALL be preserved; cross-source order is not guaranteed (issue logic stalls on pending_o).
REQ-023 pending_o[n] SHALL be combinational OR over all valid entries of both FIFOs with addr = n; pending_o[0] always 0.
REQ-024 flush_i = 1 SHALL clear both counts/pointers at the edge, suppress reg_wen_o and both readies that cycle; last_grant unchanged.
REQ-025 Pointers SHALL wrap modulo 2; count never exceeds 2 or underflows below 0.

Reset
REQ-026 rst_n = 0 SHALL asynchronously clear both FIFO counts and pointers and set last_grant = 1 (EX wins first contention).
REQ-027 During reset: reg_wen_o = 0, reg_waddr_o = 0, reg_wdata_o = 0, pending_o = 0, both readies = 0.
REQ-028 FIFO data storage need not be reset; outputs SHALL never expose it while its count is 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued writes with no partial write issued.

Verification
REQ-030 Single write: EX pushes x5=0x0000_00AA at edge 1 -> reg_wen_o=1, waddr=5, wdata=0xAA during cycle 2; pending_o=0x20 in cycle 2, 0 after edge 2.
REQ-031 Contention: EX (x1=0x11, x2=0x22) and MEM (x3=0x33, x4=0x44) push same edges -> port order x1, x3, x2, x4.
REQ-032 Backpressure: 3 EX writes with MEM also busy -> ex_wready_o=0 when count=2; third accepted only after a pop; no loss or duplication.
REQ-033 x0 drop: MEM pushes x0=0xDEAD -> mem_wready_o=1, reg_wen_o stays 0, pending_o stays 0.
REQ-034 Flush: 2 entries queued per source, flush_i=1 one cycle -> no writes that cycle, both FIFOs empty after, pending_o=0.
REQ-035 Async reset: rst_n low between edges with 3 entries queued -> reg_wen_o and pending_o drop to 0 immediately; no write after release until a new push.

Source files
------------

// File: rtl/regs_wb_arbiter_if.sv
// Writeback bus between the EX/MEM producers and the register-file arbiter.
interface regs_wb_arbiter_if;
    logic        ex_wvalid_i;
    logic        ex_wready_o;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        mem_wvalid_i;
    logic        mem_wready_o;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic [31:0] pending_o;

    modport master (
        output ex_wvalid_i, ex_waddr_i, ex_wdata_i,
        output mem_wvalid_i, mem_waddr_i, mem_wdata_i,
        input  ex_wready_o, mem_wready_o,
        input  reg_wen_o, reg_waddr_o, reg_wdata_o, pending_o
    );

    modport slave (
        input  ex_wvalid_i, ex_waddr_i, ex_wdata_i,
        input  mem_wvalid_i, mem_waddr_i, mem_wdata_i,
        output ex_wready_o, mem_wready_o,
        output reg_wen_o, reg_waddr_o, reg_wdata_o, pending_o
    );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Two-source writeback arbiter: per-source FIFOs feeding one register-file write
// port with alternating priority under contention and a pending-register scoreboard.
module regs_wb_src_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push_valid,
    input  logic [4:0]  push_addr,
    input  logic [31:0] push_data,
    output logic        push_ready,
    input  logic        pop,
    output logic        head_valid,
    output logic [4:0]  head_addr,
    output logic [31:0] head_data,
    output logic [31:0] pending
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr, rd_ptr, idx;
    logic [CW-1:0] count;
    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic          push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness is held low through reset so producers never see a phantom slot.
    assign push_ready = rst_n && (count < CW'(DEPTH)) && !flush;
    assign push       = push_valid && push_ready && (push_addr != 5'd0);
    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign head_addr  = addr_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    // Only slots inside the occupied window contribute; stale storage is ignored.
    always_comb begin
        pending = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = PW'((int'(rd_ptr) + k) % DEPTH);
            if (CW'(k) < count) pending[addr_q[idx]] = 1'b1;
        end
        pending[0] = 1'b0;
    end
endmodule

module regs_wb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    regs_wb_arbiter_if.slave   bus
);
    localparam int NSRC = 2;  // 0 = EX, 1 = MEM

    logic [NSRC-1:0]       src_valid, src_ready, head_valid, pop;
    logic [NSRC-1:0][4:0]  src_addr, head_addr;
    logic [NSRC-1:0][31:0] src_data, head_data, src_pending;
    logic                  grant, last_grant, wen;

    assign src_valid = {bus.mem_wvalid_i, bus.ex_wvalid_i};
    assign src_addr  = {bus.mem_waddr_i,  bus.ex_waddr_i};
    assign src_data  = {bus.mem_wdata_i,  bus.ex_wdata_i};

    generate
        for (genvar g = 0; g < NSRC; g++) begin : g_src
            regs_wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush      (flush_i),
                .push_valid (src_valid[g]),
                .push_addr  (src_addr[g]),
                .push_data  (src_data[g]),
                .push_ready (src_ready[g]),
                .pop        (pop[g]),
                .head_valid (head_valid[g]),
                .head_addr  (head_addr[g]),
                .head_data  (head_data[g]),
                .pending    (src_pending[g])
            );
        end
    endgenerate

    // Under contention the source that did not win last time is granted.
    always_comb begin
        grant = 1'b0;
        if (&head_valid)       grant = ~last_grant;
        else if (head_valid[1]) grant = 1'b1;
    end

    assign wen = (|head_valid) && !flush_i;
    assign pop = wen ? (grant ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   last_grant <= 1'b1;
        else if (wen) last_grant <= grant;
    end

    assign bus.ex_wready_o  = src_ready[0];
    assign bus.mem_wready_o = src_ready[1];
    assign bus.reg_wen_o    = wen;
    assign bus.reg_waddr_o  = wen ? head_addr[grant] : 5'd0;
    assign bus.reg_wdata_o  = wen ? head_data[grant] : 32'd0;
    assign bus.pending_o    = src_pending[0] | src_pending[1];
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for the writeback arbiter: reset, contention, backpressure,
// x0 drop, flush and asynchronous reset, each with hand-derived port values.
module tb_regs_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic flush_i;
    int   checks = 0;
    int   errors = 0;

    regs_wb_arbiter_if bus ();

    regs_wb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_port(input string tag, input logic wen, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".wen"},   {31'd0, bus.reg_wen_o}, {31'd0, wen});
        chk({tag, ".waddr"}, {27'd0, bus.reg_waddr_o}, {27'd0, a});
        chk({tag, ".wdata"}, bus.reg_wdata_o, d);
    endtask

    task automatic drive_ex(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.ex_wvalid_i = v; bus.ex_waddr_i = a; bus.ex_wdata_i = d;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.mem_wvalid_i = v; bus.mem_waddr_i = a; bus.mem_wdata_i = d;
    endtask

    task automatic idle();
        drive_ex(1'b0, 5'd0, 32'd0);
        drive_mem(1'b0, 5'd0, 32'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0;
        idle();

        // reset state
        #2;
        chk_port("rst", 1'b0, 5'd0, 32'd0);
        chk("rst.pending", bus.pending_o, 32'd0);
        chk("rst.ex_rdy",  {31'd0, bus.ex_wready_o}, 32'd0);
        chk("rst.mem_rdy", {31'd0, bus.mem_wready_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.ex_rdy",  {31'd0, bus.ex_wready_o}, 32'd1);
        chk("rel.mem_rdy", {31'd0, bus.mem_wready_o}, 32'd1);
        cyc();

        // contention: expected port order x1, x3, x2, x4
        drive_ex(1'b1, 5'd1, 32'h11); drive_mem(1'b1, 5'd3, 32'h33);
        cyc();
        drive_ex(1'b1, 5'd2, 32'h22); drive_mem(1'b1, 5'd4, 32'h44);
        #1; chk_port("cont0", 1'b1, 5'd1, 32'h11);
        cyc();
        idle();
        #1; chk_port("cont1", 1'b1, 5'd3, 32'h33);
        chk("cont1.pending", bus.pending_o, 32'h0000_001C);
        chk("cont1.mem_rdy", {31'd0, bus.mem_wready_o}, 32'd0);
        cyc();
        #1; chk_port("cont2", 1'b1, 5'd2, 32'h22);
        cyc();
        #1; chk_port("cont3", 1'b1, 5'd4, 32'h44);
        cyc();
        #1; chk_port("cont.idle", 1'b0, 5'd0, 32'd0);

        // single write
        drive_ex(1'b1, 5'd5, 32'hAA);
        #1; chk("sw.ex_rdy", {31'd0, bus.ex_wready_o}, 32'd1);
        chk("sw.pre_wen", {31'd0, bus.reg_wen_o}, 32'd0);
        cyc();
        idle();
        #1; chk_port("sw", 1'b1, 5'd5, 32'hAA);
        chk("sw.pending", bus.pending_o, 32'h0000_0020);
        cyc();
        #1; chk("sw.post_wen", {31'd0, bus.reg_wen_o}, 32'd0);
        chk("sw.post_pending", bus.pending_o, 32'd0);

        // backpressure: expected port order x9, x6, x10, x7, x8
        drive_ex(1'b1, 5'd6, 32'h66); drive_mem(1'b1, 5'd9, 32'h99);
        cyc();
        drive_ex(1'b1, 5'd7, 32'h77); drive_mem(1'b1, 5'd10, 32'hA0);
        #1; chk_port("bp0", 1'b1, 5'd9, 32'h99);
        chk("bp0.ex_rdy", {31'd0, bus.ex_wready_o}, 32'd1);
        cyc();
        drive_ex(1'b1, 5'd8, 32'h88); drive_mem(1'b0, 5'd0, 32'd0);
        #1; chk_port("bp1", 1'b1, 5'd6, 32'h66);
        chk("bp1.ex_rdy", {31'd0, bus.ex_wready_o}, 32'd0);
        cyc();
        #1; chk_port("bp2", 1'b1, 5'd10, 32'hA0);
        chk("bp2.ex_rdy", {31'd0, bus.ex_wready_o}, 32'd1);
        cyc();
        idle();
        #1; chk_port("bp3", 1'b1, 5'd7, 32'h77);
        chk("bp3.ex_rdy", {31'd0, bus.ex_wready_o}, 32'd0);
        cyc();
        #1; chk_port("bp4", 1'b1, 5'd8, 32'h88);
        cyc();
        #1; chk_port("bp.idle", 1'b0, 5'd0, 32'd0);
        chk("bp.pending", bus.pending_o, 32'd0);

        // x0 write is accepted and dropped
        drive_mem(1'b1, 5'd0, 32'hDEAD);
        #1; chk("x0.mem_rdy", {31'd0, bus.mem_wready_o}, 32'd1);
        cyc();
        idle();
        #1; chk_port("x0", 1'b0, 5'd0, 32'd0);
        chk("x0.pending", bus.pending_o, 32'd0);

        // flush with three entries queued
        drive_ex(1'b1, 5'd11, 32'h111); drive_mem(1'b1, 5'd12, 32'h122);
        cyc();
        drive_ex(1'b1, 5'd13, 32'h133); drive_mem(1'b1, 5'd14, 32'h144);
        #1; chk_port("fl0", 1'b1, 5'd12, 32'h122);
        cyc();
        idle();
        #1; chk("fl.pre_pending", bus.pending_o, 32'h0000_6800);
        chk_port("fl.pre", 1'b1, 5'd11, 32'h111);
        flush_i = 1'b1;
        #1; chk_port("fl.during", 1'b0, 5'd0, 32'd0);
        chk("fl.ex_rdy",  {31'd0, bus.ex_wready_o}, 32'd0);
        chk("fl.mem_rdy", {31'd0, bus.mem_wready_o}, 32'd0);
        cyc();
        flush_i = 1'b0;
        #1; chk_port("fl.after", 1'b0, 5'd0, 32'd0);
        chk("fl.after_pending", bus.pending_o, 32'd0);
        chk("fl.after_ex_rdy", {31'd0, bus.ex_wready_o}, 32'd1);
        cyc();
        #1; chk("fl.after2_wen", {31'd0, bus.reg_wen_o}, 32'd0);

        // asynchronous reset mid-operation
        drive_ex(1'b1, 5'd15, 32'h155); drive_mem(1'b1, 5'd16, 32'h166);
        cyc();
        drive_ex(1'b1, 5'd17, 32'h177); drive_mem(1'b1, 5'd18, 32'h188);
        #1; chk_port("ar0", 1'b1, 5'd15, 32'h155);
        cyc();
        idle();
        #1; chk("ar.pending", bus.pending_o, 32'h0007_0000);
        chk_port("ar1", 1'b1, 5'd16, 32'h166);
        #2; rst_n = 1'b0;
        #1; chk_port("ar.in_rst", 1'b0, 5'd0, 32'd0);
        chk("ar.in_rst_pending", bus.pending_o, 32'd0);
        chk("ar.in_rst_ex_rdy", {31'd0, bus.ex_wready_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        #1; chk_port("ar.rel0", 1'b0, 5'd0, 32'd0);
        chk("ar.rel0_pending", bus.pending_o, 32'd0);
        cyc();
        #1; chk_port("ar.rel1", 1'b0, 5'd0, 32'd0);
        drive_ex(1'b1, 5'd19, 32'h199);
        cyc();
        idle();
        #1; chk_port("ar.new", 1'b1, 5'd19, 32'h199);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
